// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM state encoding, PC-source constants and
// the bundle of stall/refresh controls produced by the hazard unit.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W   = 5;
    localparam int PCSRC_W = 2;
    localparam int WAIT_W  = 8;

    // Hazard FSM states, also exported on state_o.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_LDUSE = 2'd1;
    localparam logic [1:0] ST_MWAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // PC source value meaning sequential fetch (no branch/jump redirect).
    localparam logic [PCSRC_W-1:0] PCSRC_NONE = '0;

    // One bit per pipeline register hold/zero control.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic refresh_d;
        logic refresh_e;
        logic refresh_m;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Register-match comparator: flags when an enabled producer writes a
// non-zero register that either consumer source field reads. Used for the
// load-use check and reusable for forwarding selection.
module hazard_cmp #(
    parameter int REG_W = 5
) (
    input  logic             en,
    input  logic [REG_W-1:0] dst,
    input  logic [REG_W-1:0] src_a,
    input  logic [REG_W-1:0] src_b,
    output logic             hit
);

    // Register zero is hard-wired, so writes to it never create a dependency.
    assign hit = en & (dst != '0) & ((dst == src_a) | (dst == src_b));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves redirects, data-memory waits and
// load-use dependencies into stall/refresh controls, with a memory-wait
// abort and saturating performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REG_W-1:0]   rsD,
    input  logic [REG_W-1:0]   rtD,
    input  logic [REG_W-1:0]   writeRegE,
    input  logic               MemtoRegE,
    input  logic               RegWriteE,
    input  logic [PCSRC_W-1:0] PCSrcM,
    input  logic               mem_busy,
    output logic               stallF,
    output logic               stallD,
    output logic               stallE,
    output logic               stallM,
    output logic               refreshD,
    output logic               refreshE,
    output logic               refreshM,
    output logic [1:0]         state_o,
    output logic               mem_timeout,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_events
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              timeout_reg;
    logic              timeout_set;
    logic              flush_take;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              lu;
    logic              rd;
    logic              eval_rules;
    hz_ctrl_t          ctrl;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_cmp #(
        .REG_W (REG_W)
    ) u_lu_cmp (
        .en    (MemtoRegE & RegWriteE),
        .dst   (writeRegE),
        .src_a (rsD),
        .src_b (rtD),
        .hit   (lu)
    );

    assign rd = (PCSrcM != PCSRC_NONE);

    // Next-state and control decode; a busy memory in MWAIT overrides
    // everything, otherwise the redirect > busy > load-use priority applies.
    always_comb begin
        ctrl        = CTRL_IDLE;
        state_nxt   = ST_RUN;
        wait_nxt    = '0;
        timeout_set = 1'b0;
        flush_take  = 1'b0;
        eval_rules  = 1'b1;

        if (state == ST_MWAIT && mem_busy) begin
            eval_rules = 1'b0;
            if (wait_cnt < WAIT_LIM) begin
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.stall_e = 1'b1;
                ctrl.stall_m = 1'b1;
                wait_nxt     = wait_cnt + WAIT_W'(1);
                state_nxt    = ST_MWAIT;
            end else begin
                // Abort: drop the stuck memory op, keep the front end held.
                ctrl.stall_f   = 1'b1;
                ctrl.stall_d   = 1'b1;
                ctrl.stall_e   = 1'b1;
                ctrl.refresh_m = 1'b1;
                timeout_set    = 1'b1;
                state_nxt      = ST_RUN;
            end
        end

        if (eval_rules) begin
            if (rd) begin
                ctrl.refresh_d = 1'b1;
                ctrl.refresh_e = 1'b1;
                ctrl.refresh_m = 1'b1;
                flush_take     = 1'b1;
                state_nxt      = ST_FLUSH;
            end else if (mem_busy) begin
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.stall_e = 1'b1;
                ctrl.stall_m = 1'b1;
                wait_nxt     = WAIT_W'(1);
                state_nxt    = ST_MWAIT;
            end else if (lu) begin
                ctrl.stall_f   = 1'b1;
                ctrl.stall_d   = 1'b1;
                ctrl.refresh_e = 1'b1;
                state_nxt      = ST_LDUSE;
            end else begin
                state_nxt = ST_RUN;
            end
        end
    end

    // State, wait counter, sticky abort flag and performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            timeout_reg <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end
            if (ctrl.stall_f) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_take) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    // Reset masks every output immediately, before the registers clear.
    assign stallF       = ~reset & ctrl.stall_f;
    assign stallD       = ~reset & ctrl.stall_d;
    assign stallE       = ~reset & ctrl.stall_e;
    assign stallM       = ~reset & ctrl.stall_m;
    assign refreshD     = ~reset & ctrl.refresh_d;
    assign refreshE     = ~reset & ctrl.refresh_e;
    assign refreshM     = ~reset & ctrl.refresh_m;
    assign state_o      = reset ? ST_RUN : state;
    assign mem_timeout  = ~reset & timeout_reg;
    assign stall_cycles = reset ? '0 : stall_cnt;
    assign flush_events = reset ? '0 : flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by randomized traffic, each cycle checked against a reference model.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TO  = 4;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_RUN   = 0;
    localparam int M_LDUSE = 1;
    localparam int M_MWAIT = 2;
    localparam int M_FLUSH = 3;

    typedef struct packed {
        logic             sf;
        logic             sd;
        logic             se;
        logic             sm;
        logic             rfd;
        logic             rfe;
        logic             rfm;
        logic [1:0]       st;
        logic             to;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fe;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rsD, rtD, writeRegE;
    logic             MemtoRegE, RegWriteE;
    logic [1:0]       PCSrcM;
    logic             mem_busy;
    logic             stallF, stallD, stallE, stallM;
    logic             refreshD, refreshE, refreshM;
    logic [1:0]       state_o;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    stim_done = 1'b0;

    // Reference model state (plain integers).
    int m_mode  = M_RUN;
    int m_wait  = 0;
    int m_to    = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rsD          (rsD),
        .rtD          (rtD),
        .writeRegE    (writeRegE),
        .MemtoRegE    (MemtoRegE),
        .RegWriteE    (RegWriteE),
        .PCSrcM       (PCSrcM),
        .mem_busy     (mem_busy),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .stallM       (stallM),
        .refreshD     (refreshD),
        .refreshE     (refreshE),
        .refreshM     (refreshM),
        .state_o      (state_o),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    // Expected outputs for this cycle from the hazard rules, then advance
    // the model to what should hold after the next clock edge.
    task automatic model_step(input logic r, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] w, input logic m2r, input logic rw,
                              input logic [1:0] pc, input logic busy, output exp_t e);
        bit lu, rdir;
        e = '0;
        if (r) begin
            m_mode = M_RUN; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
            return;
        end
        lu   = m2r && rw && (w != 0) && (w == a || w == b);
        rdir = (pc != 0);
        e.st = 2'(m_mode);
        e.to = (m_to != 0);
        e.sc = CNT_W'(m_stall);
        e.fe = CNT_W'(m_flush);
        if (m_mode == M_MWAIT && busy) begin
            if (m_wait < MEM_TO) begin
                {e.sf, e.sd, e.se, e.sm} = 4'b1111;
                m_wait = m_wait + 1;
            end else begin
                {e.sf, e.sd, e.se, e.rfm} = 4'b1111;
                m_to = 1; m_mode = M_RUN; m_wait = 0;
            end
        end else if (rdir) begin
            {e.rfd, e.rfe, e.rfm} = 3'b111;
            m_mode = M_FLUSH;
            if (m_flush < CNT_MAX) m_flush = m_flush + 1;
        end else if (busy) begin
            {e.sf, e.sd, e.se, e.sm} = 4'b1111;
            m_mode = M_MWAIT; m_wait = 1;
        end else if (lu) begin
            {e.sf, e.sd, e.rfe} = 3'b111;
            m_mode = M_LDUSE;
        end else begin
            m_mode = M_RUN;
        end
        if (e.sf && m_stall < CNT_MAX) m_stall = m_stall + 1;
    endtask

    // Apply one cycle of inputs and queue the expected response.
    task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] w, input logic m2r, input logic rw,
                        input logic [1:0] pc, input logic busy, input string tag);
        exp_t e;
        @(negedge clk);
        reset = r; rsD = a; rtD = b; writeRegE = w;
        MemtoRegE = m2r; RegWriteE = rw; PCSrcM = pc; mem_busy = busy;
        model_step(r, a, b, w, m2r, rw, pc, busy, e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, tag);
    endtask

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        reset = 1'b1; rsD = '0; rtD = '0; writeRegE = '0;
        MemtoRegE = 1'b0; RegWriteE = 1'b0; PCSrcM = '0; mem_busy = 1'b0;

        step(1'b1, 0, 0, 0, 0, 0, 2'b00, 0, "reset0");
        step(1'b1, 0, 0, 0, 0, 0, 2'b00, 0, "reset1");
        idle("post_reset");

        // Load to $5 in EX with rsD=5, then the load moves on to MEM.
        step(1'b0, 5'd5, 5'd9, 5'd5, 1'b1, 1'b1, 2'b00, 0, "ldu_hit");
        step(1'b0, 5'd5, 5'd9, 5'd0, 1'b0, 1'b0, 2'b00, 0, "ldu_release");
        idle("ldu_back_run");

        // Load targeting $0 never stalls.
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 0, "ld_r0");
        // Load-use via rt and back-to-back load-use from LDUSE.
        step(1'b0, 5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 2'b00, 0, "ldu_rt");
        step(1'b0, 5'd8, 5'd2, 5'd8, 1'b1, 1'b1, 2'b00, 0, "ldu_b2b");
        idle("ldu_b2b_end");

        // Redirect beats busy and load-use.
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 2'b01, 1, "rd_prio");
        idle("rd_flush_state");

        // Memory busy for three cycles, then release.
        step(1'b0, 0, 0, 0, 0, 0, 2'b00, 1, "busy_c1");
        step(1'b0, 0, 0, 0, 0, 0, 2'b00, 1, "busy_c2");
        step(1'b0, 0, 0, 0, 0, 0, 2'b00, 1, "busy_c3");
        idle("busy_release");
        idle("busy_run");

        // Zero-cycle release into a pending redirect.
        step(1'b0, 0, 0, 0, 0, 0, 2'b00, 1, "busy_rd_a");
        step(1'b0, 0, 0, 0, 0, 0, 2'b10, 0, "busy_rd_rel");
        idle("busy_rd_end");

        // Memory stuck busy: abort after the wait limit, flag sticks.
        for (int i = 0; i < 7; i++) step(1'b0, 0, 0, 0, 0, 0, 2'b00, 1, "stuck_busy");
        idle("timeout_sticky0");
        idle("timeout_sticky1");
        step(1'b1, 0, 0, 0, 0, 0, 2'b00, 0, "timeout_reset");
        idle("timeout_cleared");

        // Reset during the second wait cycle abandons the wait.
        step(1'b0, 0, 0, 0, 0, 0, 2'b00, 1, "mw_rst_c1");
        step(1'b0, 0, 0, 0, 0, 0, 2'b00, 1, "mw_rst_c2");
        step(1'b1, 0, 0, 0, 0, 0, 2'b00, 1, "mw_rst_pulse");
        idle("mw_rst_after");
        // Reset during FLUSH.
        step(1'b0, 0, 0, 0, 0, 0, 2'b11, 0, "fl_rst_rd");
        step(1'b1, 0, 0, 0, 0, 0, 2'b00, 0, "fl_rst_pulse");
        idle("fl_rst_after");

        // Randomized traffic; small register range to provoke matches.
        for (int i = 0; i < 800; i++) begin
            logic       r, m2r, rw, busy;
            logic [4:0] a, b, w;
            logic [1:0] pc;
            r    = ($urandom_range(0, 99) == 0);
            a    = 5'($urandom_range(0, 3));
            b    = 5'($urandom_range(0, 3));
            w    = 5'($urandom_range(0, 3));
            m2r  = ($urandom_range(0, 99) < 60);
            rw   = ($urandom_range(0, 99) < 80);
            pc   = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
            busy = ($urandom_range(0, 99) < (i < 400 ? 35 : 80));
            step(r, a, b, w, m2r, rw, pc, busy, "random");
        end
        idle("tail");
        stim_done = 1'b1;
    end

    // Monitor: every cycle the DUT presents outputs, compare with the queue.
    initial begin
        exp_t e, act;
        string tag;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                tag = tag_q.pop_front();
                act = '{stallF, stallD, stallE, stallM, refreshD, refreshE, refreshM,
                        state_o, mem_timeout, stall_cycles, flush_events};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s @%0t: got stall=%b%b%b%b refresh=%b%b%b state=%0d to=%b sc=%0d fe=%0d, expected stall=%b%b%b%b refresh=%b%b%b state=%0d to=%b sc=%0d fe=%0d",
                             tag, $time, act.sf, act.sd, act.se, act.sm, act.rfd, act.rfe, act.rfm,
                             act.st, act.to, act.sc, act.fe, e.sf, e.sd, e.se, e.sm,
                             e.rfd, e.rfe, e.rfm, e.st, e.to, e.sc, e.fe);
                end
            end
        end
    end

    // Bounded wait for the stimulus, drain the scoreboard, report.
    initial begin
        for (int i = 0; i < 20000 && !stim_done; i++) @(posedge clk);
        checks++;
        if (!stim_done) begin
            errors++;
            $display("FAIL stim_timeout: got done=%b, expected done=1", stim_done);
        end
        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
